// File: rtl/pos_seq_ctrl.sv
// pos_seq_ctrl: steps the LUT slot select through [first_slt..last_slt] (modulo wrap),
// holding each slot for max(dwell,1) cycles, single-pass or looping, with abort.
// Optional feature macro: POS_SEQ_HOLD_EN (adds input hold that freezes the sequence in RUN).
// Ports:
//   iclk, irst             clock, synchronous active-high reset
//   start, stop            begin request (IDLE only) / abort (any state, wins over start and hold)
//   loop_en, dwell,
//   first_slt, last_slt    sequence config, captured on an accepted start
//   hold                   (POS_SEQ_HOLD_EN only) freeze counter and slot while in RUN
//   slt, slt_vld           registered slot select and its valid flag
//   step                   one-cycle pulse on every slot load/change
//   busy, done             high in RUN / one-cycle pulse when a single pass completes
module pos_seq_ctrl #(
    parameter int DWELL_W = 16,
    parameter int SLT_W   = 2
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic               start,
    input  logic               stop,
`ifdef POS_SEQ_HOLD_EN
    input  logic               hold,
`endif
    input  logic               loop_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SLT_W-1:0]   first_slt,
    input  logic [SLT_W-1:0]   last_slt,
    output logic [SLT_W-1:0]   slt,
    output logic               slt_vld,
    output logic               step,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t             state_q;
    logic [DWELL_W-1:0] cnt_q, dwell_q, reload_d, start_cnt_d;
    logic [SLT_W-1:0]   slt_q, first_q, last_q;
    logic               loop_q, vld_q, step_q, busy_q, done_q, hold_w;
`ifdef POS_SEQ_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif
    // counter holds (cycles per slot - 1); dwell of 0 behaves like 1
    assign reload_d    = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
    assign start_cnt_d = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dwell_q <= '0;
            slt_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            vld_q   <= 1'b0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start && !stop) begin
                    loop_q  <= loop_en;
                    dwell_q <= dwell;
                    first_q <= first_slt;
                    last_q  <= last_slt;
                    slt_q   <= first_slt;
                    cnt_q   <= start_cnt_d;
                    vld_q   <= 1'b1;
                    busy_q  <= 1'b1;
                    step_q  <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    if (stop) begin
                        vld_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (!hold_w) begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - DWELL_W'(1);
                        end else if (slt_q != last_q || loop_q) begin
                            // at the end of the range only a looping run gets here: restart at first
                            slt_q  <= (slt_q == last_q) ? first_q : slt_q + SLT_W'(1);
                            cnt_q  <= reload_d;
                            step_q <= 1'b1;
                        end else begin
                            vld_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign slt     = slt_q;
    assign slt_vld = vld_q;
    assign step    = step_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_pos_seq_ctrl.sv
// tb_pos_seq_ctrl: directed literal checks plus randomized run against a time-based model
module tb_pos_seq_ctrl;
    logic        iclk, irst, start, stop, loop_en;
    logic [15:0] dwell;
    logic [1:0]  first_slt, last_slt, slt;
    logic        slt_vld, step, busy, done;
    logic [5:0]  outv;
    int          checks = 0, failures = 0;
    logic        chk_en = 1'b0;

    pos_seq_ctrl #(.DWELL_W(16), .SLT_W(2)) dut (
        .iclk(iclk), .irst(irst), .start(start), .stop(stop), .loop_en(loop_en),
        .dwell(dwell), .first_slt(first_slt), .last_slt(last_slt),
        .slt(slt), .slt_vld(slt_vld), .step(step), .busy(busy), .done(done)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    assign outv = {slt_vld, busy, step, done, slt};

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: {vld,busy,step,done,slt} got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is described by elapsed cycles t since the start was accepted.
    // Slot index k = t / D, position in range = k (mod L when looping), step when t is a multiple of D.
    int         m_mode = 0;
    int         m_t = 0;
    int         m_d = 1;
    logic       m_lp;
    logic [1:0] m_f, m_l, m_hold;
    int         m_len, m_k;
    logic [1:0] e_slt;
    logic       e_vld, e_busy, e_step, e_done;

    always_comb begin
        m_len  = int'(2'(m_l - m_f)) + 1;
        m_k    = m_t / ((m_d == 0) ? 1 : m_d);
        e_slt  = m_hold;
        e_vld  = 1'b0;
        e_busy = 1'b0;
        e_step = 1'b0;
        e_done = 1'b0;
        if (m_mode == 1) begin
            e_slt  = m_f + 2'(m_lp ? (m_k % m_len) : m_k);
            e_vld  = 1'b1;
            e_busy = 1'b1;
            e_step = (m_t % ((m_d == 0) ? 1 : m_d)) == 0;
        end else if (m_mode == 2) begin
            e_slt  = m_l;
            e_done = 1'b1;
        end
    end

    always @(posedge iclk) begin
        if (irst) begin
            m_mode <= 0;
            m_t    <= 0;
            m_d    <= 1;
            m_lp   <= 1'b0;
            m_f    <= 2'd0;
            m_l    <= 2'd0;
            m_hold <= 2'd0;
        end else if (m_mode == 0) begin
            if (start && !stop) begin
                m_mode <= 1;
                m_t    <= 0;
                m_lp   <= loop_en;
                m_d    <= (dwell == 16'd0) ? 1 : int'(dwell);
                m_f    <= first_slt;
                m_l    <= last_slt;
            end
        end else if (m_mode == 1) begin
            if (stop) begin
                m_mode <= 0;
                m_hold <= e_slt;
            end else if (!m_lp && (m_t + 1 == m_len * m_d)) begin
                m_mode <= 2;
            end else begin
                m_t <= m_t + 1;
            end
        end else begin
            m_mode <= 0;
            m_hold <= m_l;
        end
    end

    always @(negedge iclk)
        if (chk_en) check("cycle", outv, {e_vld, e_busy, e_step, e_done, e_slt});

    logic [5:0] t1 [10] = '{6'b111000, 6'b110000, 6'b111001, 6'b110001, 6'b111010,
                            6'b110010, 6'b111011, 6'b110011, 6'b000111, 6'b000011};
    logic [5:0] t2 [5]  = '{6'b111011, 6'b111000, 6'b111001, 6'b000101, 6'b000001};
    logic [5:0] t5 [4]  = '{6'b111000, 6'b111001, 6'b111010, 6'b000000};

    initial begin
        irst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        dwell = 16'd0; first_slt = 2'd0; last_slt = 2'd0;
        repeat (3) @(negedge iclk);
        check("reset", outv, 6'b000000);
        chk_en = 1'b1;
        irst = 1'b0;
        @(negedge iclk);
        // single pass 0..3, dwell 2; a start pulse and config change mid-run must not matter
        start = 1'b1; first_slt = 2'd0; last_slt = 2'd3; dwell = 16'd2; loop_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge iclk);
            check("pass_0_3", outv, t1[i]);
            start = (i == 2);
            if (i == 2) begin first_slt = 2'd2; dwell = 16'd7; loop_en = 1'b1; end
        end
        // wrap-around range 3,0,1 with dwell 1
        start = 1'b1; first_slt = 2'd3; last_slt = 2'd1; dwell = 16'd1; loop_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge iclk);
            check("wrap_3_1", outv, t2[i]);
            start = 1'b0;
        end
        // dwell 0 single looping slot, then stop
        start = 1'b1; first_slt = 2'd2; last_slt = 2'd2; dwell = 16'd0; loop_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge iclk);
            check("loop_stop", outv, (i < 4) ? 6'b111010 : 6'b000010);
            start = 1'b0;
            stop  = (i == 3);
        end
        // start and stop together in IDLE: stays idle
        start = 1'b1; stop = 1'b1; first_slt = 2'd0; last_slt = 2'd3; dwell = 16'd1; loop_en = 1'b0;
        @(negedge iclk);
        check("start_stop", outv, 6'b000010);
        start = 1'b0; stop = 1'b0;
        @(negedge iclk);
        // reset mid-run at slt=2
        start = 1'b1; first_slt = 2'd0; last_slt = 2'd3; dwell = 16'd1; loop_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iclk);
            check("reset_mid", outv, t5[i]);
            start = 1'b0;
            irst  = (i == 2);
        end
        // randomized traffic checked every cycle against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge iclk);
            start     = ($urandom_range(0, 5) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            irst      = ($urandom_range(0, 499) == 0);
            loop_en   = 1'($urandom);
            dwell     = 16'($urandom_range(0, 4));
            first_slt = 2'($urandom);
            last_slt  = 2'($urandom);
        end
        @(negedge iclk);
        start = 1'b0; stop = 1'b0; irst = 1'b0;
        repeat (2) @(negedge iclk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
